// File: rtl/icache_mmu_param.sv
// Direct-mapped, read-only instruction cache with burst line refill and fence.i flush.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_mmu_param #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_ren,
    input  logic              cpu_flush,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
`ifdef ICACHE_STATS_EN
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BYTES   = DATA_W / 8;
    localparam int OFF_W   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int WIL_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - OFF_W - WIL_W - IDX_W;
    localparam int CNT_W   = (WIL_W > 0) ? WIL_W : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << (OFF_W + WIL_W)) - 64'd1);

    typedef enum logic [1:0] {RUN, REFILL, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  flushIdx_q, flushIdx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              flushPend_q, flushPend_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] dataMem [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tagMem  [LINES];

    logic [IDX_W-1:0]  cpuIdx, baseIdx;
    logic [TAG_W-1:0]  cpuTag, baseTag;
    logic [CNT_W-1:0]  cpuWord;
    logic              hit, lastWord, flushReq;

    assign cpuIdx   = cpu_addr[OFF_W+WIL_W +: IDX_W];
    assign cpuTag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign cpuWord  = CNT_W'((cpu_addr >> OFF_W) & ADDR_W'(WORDS_PER_LINE - 1));
    assign baseIdx  = base_q[OFF_W+WIL_W +: IDX_W];
    assign baseTag  = base_q[ADDR_W-1 -: TAG_W];
    assign hit      = valid_q[cpuIdx] && (tagMem[cpuIdx] == cpuTag);
    assign lastWord = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));
    assign flushReq = cpu_flush || flushPend_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            valid_q     <= '0;
            cnt_q       <= '0;
            flushIdx_q  <= '0;
            base_q      <= '0;
            flushPend_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            flushIdx_q  <= flushIdx_d;
            base_q      <= base_d;
            flushPend_q <= flushPend_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_ack) begin
            dataMem[baseIdx][cnt_q] <= mem_rdata;
            if (lastWord) tagMem[baseIdx] <= baseTag;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        flushIdx_d  = flushIdx_q;
        base_d      = base_q;
        flushPend_d = flushPend_q;
        unique case (state_q)
            RUN: begin
                if (flushReq) begin
                    state_d     = FLUSH;
                    flushPend_d = 1'b0;
                    flushIdx_d  = '0;
                end else if (cpu_ren && !hit) begin
                    state_d = REFILL;
                    base_d  = cpu_addr & LINE_MASK;
                    cnt_d   = '0;
                end
            end
            REFILL: begin
                if (cpu_flush) flushPend_d = 1'b1;
                if (mem_ack) begin
                    if (lastWord) begin
                        cnt_d            = '0;
                        valid_d[baseIdx] = 1'b1;
                        state_d          = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                valid_d[flushIdx_q] = 1'b0;
                if (flushIdx_q == IDX_W'(LINES - 1)) begin
                    flushIdx_d = '0;
                    state_d    = RUN;
                end else begin
                    flushIdx_d = flushIdx_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // A pending flush stalls fetch in RUN so the lookup is redone on clean state afterwards.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = rdata_q;
        rdata_d   = rdata_q;
        mem_req   = 1'b0;
        mem_addr  = '0;
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (!flushReq) begin
                        if (!cpu_ren) begin
                            cpu_ready = 1'b1;
                        end else if (hit) begin
                            cpu_ready = 1'b1;
                            cpu_rdata = dataMem[cpuIdx][cpuWord];
                            rdata_d   = dataMem[cpuIdx][cpuWord];
                        end
                    end
                end
                REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = base_q + (ADDR_W'(cnt_q) << OFF_W);
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] statHits_q, statMisses_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statHits_q   <= '0;
            statMisses_q <= '0;
        end else begin
            if (state_q == RUN && cpu_ren && hit && statHits_q != '1)
                statHits_q <= statHits_q + 32'd1;
            if (state_q == RUN && state_d == REFILL && statMisses_q != '1)
                statMisses_q <= statMisses_q + 32'd1;
        end
    end

    assign stat_hits   = statHits_q;
    assign stat_misses = statMisses_q;
`endif

endmodule

// File: tb/tb_icache_mmu_param.sv
// Directed self-checking bench for icache_mmu_param (default geometry: 64 lines x 4 words).
// Stats counters are checked when ICACHE_STATS_EN is defined.
module tb_icache_mmu_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_ren;
    logic        cpu_flush;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int checkCount = 0;
    int errorCount = 0;

    icache_mmu_param dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_ren   (cpu_ren),
        .cpu_flush (cpu_flush),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
`ifdef ICACHE_STATS_EN
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
`endif
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing memory contents: upper half scrambles the address so words are distinguishable.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ren, input logic [31:0] addr);
        cpu_ren  = ren;
        cpu_addr = addr;
        #1;
    endtask

    // Serve one line refill; optionally delay each ack and pulse cpu_flush while waiting on one word.
    task automatic refillLine(input logic [31:0] base, input int delay, input int flushWord);
        for (int w = 0; w < 4; w++) begin
            for (int d = 0; d < delay; d++) begin
                checkOutput("wait_req", mem_req, 1'b1);
                checkOutput("wait_addr", mem_addr, base + 32'(w * 4));
                checkOutput("wait_ready", cpu_ready, 1'b0);
                cpu_flush = (w == flushWord && d == 0);
                tick();
                cpu_flush = 1'b0;
            end
            checkOutput("refill_req", mem_req, 1'b1);
            checkOutput("refill_addr", mem_addr, base + 32'(w * 4));
            checkOutput("refill_ready", cpu_ready, 1'b0);
            mem_ack   = 1'b1;
            mem_rdata = memWord(base + 32'(w * 4));
            tick();
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
    endtask

    task automatic expectMissAndRefill(input logic [31:0] addr, input int delay, input int flushWord);
        applyStimulus(1'b1, addr);
        checkOutput("miss_ready", cpu_ready, 1'b0);
        checkOutput("miss_noreq", mem_req, 1'b0);
        tick();
        refillLine(addr & 32'hFFFF_FFF0, delay, flushWord);
    endtask

    task automatic expectHit(input logic [31:0] addr);
        applyStimulus(1'b1, addr);
        checkOutput("hit_ready", cpu_ready, 1'b1);
        checkOutput("hit_rdata", cpu_rdata, memWord(addr));
        checkOutput("hit_noreq", mem_req, 1'b0);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        cpu_ren   = 1'b0;
        cpu_addr  = '0;
        cpu_flush = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        checkOutput("rst_ready", cpu_ready, 1'b0);
        checkOutput("rst_req", mem_req, 1'b0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        checkOutput("rst_rdata", cpu_rdata, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("idle_ready", cpu_ready, 1'b1);
`ifdef ICACHE_STATS_EN
        checkOutput("rst_hits", stat_hits, 32'd0);
        checkOutput("rst_misses", stat_misses, 32'd0);
`endif

        // Cold miss, four-word refill, then the whole line hits.
        expectMissAndRefill(32'h100, 0, -1);
        expectHit(32'h100);
        expectHit(32'h104);
        expectHit(32'h108);
        expectHit(32'h10C);
        applyStimulus(1'b0, 32'h200);
        checkOutput("idle_hold_ready", cpu_ready, 1'b1);
        checkOutput("idle_hold_rdata", cpu_rdata, memWord(32'h10C));
`ifdef ICACHE_STATS_EN
        checkOutput("stat_misses_t12", stat_misses, 32'd1);
        checkOutput("stat_hits_t12", stat_hits, 32'd4);
`endif

        // Conflict on index 0.
        expectMissAndRefill(32'h000, 0, -1);
        expectHit(32'h000);
        expectMissAndRefill(32'h400, 0, -1);
        expectHit(32'h400);
        expectMissAndRefill(32'h000, 0, -1);
        expectHit(32'h000);
        expectHit(32'h10C);

        // Slow memory: five idle cycles before each ack.
        expectMissAndRefill(32'h208, 5, -1);
        expectHit(32'h208);

        // Flush pulsed mid-refill: refill completes, then a 64-cycle flush.
        expectMissAndRefill(32'h300, 1, 1);
        applyStimulus(1'b0, 32'h300);
        checkOutput("flush_pend_ready", cpu_ready, 1'b0);
        tick();
        for (int i = 0; i < 64; i++) begin
            checkOutput("flush_ready", cpu_ready, 1'b0);
            checkOutput("flush_noreq", mem_req, 1'b0);
            tick();
        end
        checkOutput("post_flush_ready", cpu_ready, 1'b1);
        expectMissAndRefill(32'h300, 0, -1);
        expectHit(32'h300);
        expectMissAndRefill(32'h104, 0, -1);
        expectHit(32'h104);

        // Reset during word 2 of a refill.
        applyStimulus(1'b1, 32'h500);
        tick();
        for (int w = 0; w < 2; w++) begin
            mem_ack   = 1'b1;
            mem_rdata = memWord(32'h500 + 32'(w * 4));
            tick();
        end
        mem_ack = 1'b0;
        #1;
        checkOutput("pre_rst_req", mem_req, 1'b1);
        checkOutput("pre_rst_addr", mem_addr, 32'h508);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_req", mem_req, 1'b0);
        checkOutput("mid_rst_addr", mem_addr, 32'h0);
        checkOutput("mid_rst_ready", cpu_ready, 1'b0);
        tick();
        reset = 1'b0;
        expectMissAndRefill(32'h500, 0, -1);
        expectHit(32'h500);
        applyStimulus(1'b0, 32'h500);
`ifdef ICACHE_STATS_EN
        checkOutput("stat_misses_end", stat_misses, 32'd1);
        checkOutput("stat_hits_end", stat_hits, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
